// File: rtl/vga_pkg.sv
// Shared VGA definitions: display geometry, porch timing, pixel color codes
// and the fill-engine state encoding.
package vga_pkg;

   localparam int unsigned COORD_BITS = 11;

   // 1280x1024@60 geometry
   localparam int unsigned HdDefault = 1280;
   localparam int unsigned VdDefault = 1024;
   localparam int unsigned HFront    = 48;
   localparam int unsigned HSync     = 112;
   localparam int unsigned HBack     = 248;
   localparam int unsigned VFront    = 1;
   localparam int unsigned VSync     = 3;
   localparam int unsigned VBack     = 38;

   // Color codes shared with the scan-out decoder
   typedef enum logic [1:0] {
      ColWhite = 2'd0,
      ColBlack = 2'd1,
      ColBlue  = 2'd2,
      ColGreen = 2'd3
   } color_e;

   typedef logic [COORD_BITS-1:0] coord_t;

   // Fill FSM encoding
   typedef logic [0:0] fill_state_t;
   localparam fill_state_t StIdle = 1'b0;
   localparam fill_state_t StFill = 1'b1;

   function automatic coord_t coord_min(input coord_t a, input coord_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic coord_t coord_max(input coord_t a, input coord_t b);
      return (a < b) ? b : a;
   endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Nested x/y raster counter: x runs fastest from xmin to xmax, then y advances.
// Holds at (xmax,ymax) so it never wraps past the rectangle.
module fb_raster_counter
   import vga_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  load_i,
   input  logic [COORD_BITS-1:0] load_x_i,
   input  logic [COORD_BITS-1:0] load_y_i,
   input  logic [COORD_BITS-1:0] xmin_i,
   input  logic [COORD_BITS-1:0] xmax_i,
   input  logic [COORD_BITS-1:0] ymax_i,
   input  logic                  en_i,
   output logic [COORD_BITS-1:0] x_o,
   output logic [COORD_BITS-1:0] y_o,
   output logic                  last_o
);

   logic [COORD_BITS-1:0] x_q, x_d;
   logic [COORD_BITS-1:0] y_q, y_d;

   assign last_o = (x_q == xmax_i) && (y_q == ymax_i);

   // Next position: load wins, otherwise step in raster order
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (load_i) begin
         x_d = load_x_i;
         y_d = load_y_i;
      end else if (en_i && !last_o) begin
         if (x_q == xmax_i) begin
            x_d = xmin_i;
            y_d = y_q + coord_t'(1);
         end else begin
            x_d = x_q + coord_t'(1);
         end
      end
   end

   // Position registers
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for the framebuffer write port. Accepts one command
// per valid/ready handshake and emits one pixel write per clock in raster order.
// Optional feature: define FB_RECT_FILL_CLIP_EN to clip rectangles to the screen.
module fb_rect_fill
   import vga_pkg::*;
#(
   parameter int unsigned HD = HdDefault,
   parameter int unsigned VD = VdDefault
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [COORD_BITS-1:0] cmd_x0_i,
   input  logic [COORD_BITS-1:0] cmd_x1_i,
   input  logic [COORD_BITS-1:0] cmd_y0_i,
   input  logic [COORD_BITS-1:0] cmd_y1_i,
   input  logic [1:0]            cmd_color_i,
   input  logic                  abort_i,
   output logic                  we_o,
   output logic [COORD_BITS-1:0] addr_x_o,
   output logic [COORD_BITS-1:0] addr_y_o,
   output logic [1:0]            color_o,
   output logic                  busy_o,
   output logic                  done_o
);

   // The screen must fit the coordinate width
   if (HD >= (1 << COORD_BITS) || VD >= (1 << COORD_BITS)) begin : g_bad_geometry
      $error("fb_rect_fill: HD/VD do not fit in COORD_BITS");
   end

   fill_state_t state_q, state_d;
   coord_t      xmin_q, xmin_d;
   coord_t      xmax_q, xmax_d;
   coord_t      ymax_q, ymax_d;
   color_e      color_q, color_d;
   logic        done_q, done_d;

   coord_t xmin_n, xmax_n, ymin_n, ymax_n;
   coord_t xmax_c, ymax_c;
   logic   off_screen;
   logic   accept;
   logic   cnt_load, cnt_en, cnt_last;

   assign xmin_n = coord_min(cmd_x0_i, cmd_x1_i);
   assign xmax_n = coord_max(cmd_x0_i, cmd_x1_i);
   assign ymin_n = coord_min(cmd_y0_i, cmd_y1_i);
   assign ymax_n = coord_max(cmd_y0_i, cmd_y1_i);

`ifdef FB_RECT_FILL_CLIP_EN
   localparam coord_t XLimit = coord_t'(HD);
   localparam coord_t YLimit = coord_t'(VD);
   localparam coord_t XLast  = coord_t'(HD - 1);
   localparam coord_t YLast  = coord_t'(VD - 1);

   assign xmax_c     = (xmax_n > XLast) ? XLast : xmax_n;
   assign ymax_c     = (ymax_n > YLast) ? YLast : ymax_n;
   // Fully off-screen: accept, write nothing, report done next cycle
   assign off_screen = (xmin_n >= XLimit) || (ymin_n >= YLimit);
`else
   assign xmax_c     = xmax_n;
   assign ymax_c     = ymax_n;
   assign off_screen = 1'b0;
`endif

   assign accept = cmd_valid_i && (state_q == StIdle);

   // FSM, handshake and command latching
   always_comb begin
      state_d  = state_q;
      xmin_d   = xmin_q;
      xmax_d   = xmax_q;
      ymax_d   = ymax_q;
      color_d  = color_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               xmin_d  = xmin_n;
               xmax_d  = xmax_c;
               ymax_d  = ymax_c;
               color_d = color_e'(cmd_color_i);
               if (off_screen) begin
                  done_d = 1'b1;
               end else begin
                  cnt_load = 1'b1;
                  state_d  = StFill;
               end
            end
         end
         StFill: begin
            if (abort_i || cnt_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and command registers
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= StIdle;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         color_q <= ColWhite;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         color_q <= color_d;
         done_q  <= done_d;
      end
   end

   fb_raster_counter u_raster (
      .clk_i    (clk_i),
      .arstn_i  (arstn_i),
      .load_i   (cnt_load),
      .load_x_i (xmin_n),
      .load_y_i (ymin_n),
      .xmin_i   (xmin_q),
      .xmax_i   (xmax_q),
      .ymax_i   (ymax_q),
      .en_i     (cnt_en),
      .x_o      (addr_x_o),
      .y_o      (addr_y_o),
      .last_o   (cnt_last)
   );

   // An abort suppresses the write in the very cycle it is seen
   assign we_o        = (state_q == StFill) && !abort_i;
   assign color_o     = color_q;
   assign busy_o      = (state_q == StFill);
   assign cmd_ready_o = (state_q == StIdle);
   assign done_o      = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: expected pixel writes are queued when a
// command is issued and compared as the engine emits them.
// Define FB_RECT_FILL_CLIP_EN to also exercise clipping.
module tb_fb_rect_fill;

   localparam int CB = 11;

   logic          clk;
   logic          arstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CB-1:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
   logic [1:0]    cmd_color;
   logic          abort;
   logic          we;
   logic [CB-1:0] addr_x, addr_y;
   logic [1:0]    color;
   logic          busy;
   logic          done;

   fb_rect_fill dut (
      .clk_i       (clk),
      .arstn_i     (arstn),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_x0_i    (cmd_x0),
      .cmd_x1_i    (cmd_x1),
      .cmd_y0_i    (cmd_y0),
      .cmd_y1_i    (cmd_y1),
      .cmd_color_i (cmd_color),
      .abort_i     (abort),
      .we_o        (we),
      .addr_x_o    (addr_x),
      .addr_y_o    (addr_y),
      .color_o     (color),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   int          ev_cyc = 0;
   int          acc_cyc = 0;
   bit          pending_first = 0;
   bit          accepted = 0;
   logic [31:0] exp_q[$];
   int          cmd_n_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pix(input int x, input int y, input int c);
      logic [CB-1:0] xx;
      logic [CB-1:0] yy;
      logic [1:0]    cc;
      xx = CB'(x);
      yy = CB'(y);
      cc = 2'(c);
      return {8'h00, xx, yy, cc};
   endfunction

   // One clock: sample outputs on the falling edge, return just after the rising edge
   task automatic tick();
      int n;
      @(negedge clk);
      cyc++;
      if (arstn) begin
         if (we) begin
            wr_cnt++;
            ev_cyc = cyc;
            if (pending_first) begin
               check_eq("first_write_latency", cyc, acc_cyc + 1);
               pending_first = 0;
            end
            if (exp_q.size() == 0) check_eq("unexpected_write", {31'b0, we}, 32'd0);
            else check_eq("pixel", {8'h00, addr_x, addr_y, color}, exp_q.pop_front());
         end
         if (busy && abort) ev_cyc = cyc;
         if (done) begin
            done_cnt++;
            check_eq("done_latency", cyc, ev_cyc + 1);
            check_eq("ready_at_done", {31'b0, cmd_ready}, 32'd1);
            check_eq("busy_at_done", {31'b0, busy}, 32'd0);
         end
         if (cmd_valid && cmd_ready) begin
            accepted = 1;
            acc_cyc  = cyc;
            n = (cmd_n_q.size() > 0) ? cmd_n_q.pop_front() : 0;
            if (n > 0) pending_first = 1;
            else ev_cyc = cyc;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Queue the expected writes (at most 'limit'), then present the command until accepted
   task automatic issue(input int x0, input int y0, input int x1, input int y1,
                        input int c, input int limit);
      int xmn, xmx, ymn, ymx, n;
      bit skip;
      xmn  = (x0 < x1) ? x0 : x1;
      xmx  = (x0 < x1) ? x1 : x0;
      ymn  = (y0 < y1) ? y0 : y1;
      ymx  = (y0 < y1) ? y1 : y0;
      skip = 0;
`ifdef FB_RECT_FILL_CLIP_EN
      if (xmx > 1279) xmx = 1279;
      if (ymx > 1023) ymx = 1023;
      if (xmn > 1279 || ymn > 1023) skip = 1;
`endif
      n = 0;
      if (!skip) begin
         for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
               if (n < limit) begin
                  exp_q.push_back(pix(x, y, c));
                  n++;
               end
            end
         end
      end
      cmd_n_q.push_back(n);
      cmd_x0    = CB'(x0);
      cmd_x1    = CB'(x1);
      cmd_y0    = CB'(y0);
      cmd_y1    = CB'(y1);
      cmd_color = 2'(c);
      cmd_valid = 1'b1;
      accepted  = 0;
      for (int i = 0; i < 3000 && !accepted; i++) tick();
      check_eq("accepted", {31'b0, accepted}, 32'd1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 3000 && done_cnt < target; i++) tick();
      check_eq("done_count", done_cnt, target);
      check_eq("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      int w0, d0;
      arstn     = 1'b0;
      cmd_valid = 1'b0;
      cmd_x0    = '0;
      cmd_x1    = '0;
      cmd_y0    = '0;
      cmd_y1    = '0;
      cmd_color = '0;
      abort     = 1'b0;
      #12;
      check_eq("rst_ready", {31'b0, cmd_ready}, 32'd1);
      check_eq("rst_we", {31'b0, we}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_addr", {10'b0, addr_x, addr_y}, 32'd0);
      check_eq("rst_color", {30'b0, color}, 32'd0);
      @(posedge clk);
      #1;
      arstn = 1'b1;

      // Basic fill, BLUE
      w0 = wr_cnt;
      issue(2, 3, 4, 4, 2, 1000);
      cmd_valid = 1'b0;
      wait_done(1);
      check_eq("basic_writes", wr_cnt - w0, 6);

      // Swapped corners, GREEN
      w0 = wr_cnt;
      issue(10, 7, 8, 5, 3, 1000);
      cmd_valid = 1'b0;
      wait_done(2);
      check_eq("swapped_writes", wr_cnt - w0, 9);

      // Single pixel then back-to-back single pixel at the far corner
      w0 = wr_cnt;
      issue(0, 0, 0, 0, 0, 1000);
      issue(1279, 1023, 1279, 1023, 1, 1000);
      cmd_valid = 1'b0;
      wait_done(4);
      check_eq("b2b_writes", wr_cnt - w0, 2);

      // Abort on the third write cycle
      w0 = wr_cnt;
      issue(0, 0, 99, 0, 0, 2);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && wr_cnt < w0 + 2; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done(5);
      for (int i = 0; i < 3; i++) tick();
      check_eq("abort_writes", wr_cnt - w0, 2);
      check_eq("abort_ready", {31'b0, cmd_ready}, 32'd1);

      // Abort while idle has no effect
      abort = 1'b1;
      tick();
      tick();
      abort = 1'b0;
      check_eq("idle_abort_done", done_cnt, 5);
      check_eq("idle_abort_ready", {31'b0, cmd_ready}, 32'd1);

      // Reset in the middle of a fill
      w0 = wr_cnt;
      issue(0, 0, 9, 9, 3, 1000);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      arstn = 1'b0;
      #1;
      check_eq("midrst_we", {31'b0, we}, 32'd0);
      check_eq("midrst_busy", {31'b0, busy}, 32'd0);
      check_eq("midrst_done", {31'b0, done}, 32'd0);
      check_eq("midrst_ready", {31'b0, cmd_ready}, 32'd1);
      check_eq("midrst_addr", {10'b0, addr_x, addr_y}, 32'd0);
      check_eq("midrst_color", {30'b0, color}, 32'd0);
      exp_q.delete();
      cmd_n_q.delete();
      pending_first = 0;
      d0 = done_cnt;
      tick();
      tick();
      arstn = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check_eq("midrst_no_done", done_cnt, d0);
      check_eq("midrst_partial_writes", wr_cnt - w0, 3);
      w0 = wr_cnt;
      issue(5, 6, 6, 7, 3, 1000);
      cmd_valid = 1'b0;
      wait_done(d0 + 1);
      check_eq("postrst_writes", wr_cnt - w0, 4);

`ifdef FB_RECT_FILL_CLIP_EN
      // Partially off-screen, then fully off-screen
      d0 = done_cnt;
      w0 = wr_cnt;
      issue(1278, 1022, 1300, 1030, 2, 1000);
      cmd_valid = 1'b0;
      wait_done(d0 + 1);
      check_eq("clip_writes", wr_cnt - w0, 4);
      w0 = wr_cnt;
      issue(1400, 0, 1500, 5, 1, 1000);
      cmd_valid = 1'b0;
      wait_done(d0 + 2);
      for (int i = 0; i < 3; i++) tick();
      check_eq("offscreen_writes", wr_cnt - w0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
